// File: rtl/qpu_event_timing_queue_if.sv
// ---------------------------------------------------------------------------
// qpu_event_timing_queue_if
//
// Write-back handshake between the QIU (producer) and the timed-event issue
// queue (consumer). One bundle {edata, oprand, tdata} moves on every cycle in
// which tq_i_valid and tq_i_ready are both high.
//
// Signals:
//   tq_i_valid   producer -> consumer   bundle valid
//   tq_i_ready   consumer -> producer   queue can accept this cycle
//   tq_i_edata   producer -> consumer   event data (whole event wire)
//   tq_i_oprand  producer -> consumer   event operand mask, one bit per channel
//   tq_i_tdata   producer -> consumer   absolute issue time
//
// Modports:
//   master  the QIU side (drives valid and payload)
//   slave   the queue side (drives ready)
// ---------------------------------------------------------------------------
interface qpu_event_timing_queue_if #(
    parameter int EDATA_W  = 32,
    parameter int OPRAND_W = 4,
    parameter int TIME_W   = 32
);
    logic                tq_i_valid;
    logic                tq_i_ready;
    logic [EDATA_W-1:0]  tq_i_edata;
    logic [OPRAND_W-1:0] tq_i_oprand;
    logic [TIME_W-1:0]   tq_i_tdata;

    modport master (
        output tq_i_valid,
        output tq_i_edata,
        output tq_i_oprand,
        output tq_i_tdata,
        input  tq_i_ready
    );

    modport slave (
        input  tq_i_valid,
        input  tq_i_edata,
        input  tq_i_oprand,
        input  tq_i_tdata,
        output tq_i_ready
    );
endinterface

// File: rtl/qpu_event_timing_queue.sv
// ---------------------------------------------------------------------------
// qpu_event_timing_queue
//
// Timed-event issue queue. Bundles arriving over the QIU write-back handshake
// are buffered in order in a circular buffer. The entry at the head is
// compared against the local timeline counter every cycle and is released to
// the analog/AWG event port when the timeline reaches its timestamp. The
// timeline counter is also exported so the QIU can add immediates to it.
//
// Parameters:
//   EDATA_W   event data width
//   OPRAND_W  event operand mask width
//   TIME_W    timestamp / timeline counter width
//   DEPTH     queue entries (power of two, >= 2)
//
// Ports:
//   clk            single clock
//   rst_n          synchronous active-low reset
//   tq_i           write-back handshake (slave side of qpu_event_timing_queue_if)
//   tq_run         timeline counter enable
//   tq_clr         synchronous flush of queue, timeline and late flag
//   tq_o_clk       current timeline value
//   evt_o_valid    one-cycle issue strobe
//   evt_o_edata    issued event data (held while evt_o_valid is low)
//   evt_o_oprand   issued operand mask (held while evt_o_valid is low)
//   evt_o_time     timestamp of the issued entry (held while evt_o_valid is low)
//   tq_o_late      sticky: some entry reached the head after its time
//   tq_o_count     registered occupancy
//   tq_o_empty     registered occupancy == 0
//
// Build option:
//   QPU_TQ_LATE_DROP_EN  when defined, a late head is popped and discarded
//                        without a strobe; otherwise it is issued at once.
//                        tq_o_late is set in both builds.
// ---------------------------------------------------------------------------
module qpu_event_timing_queue #(
    parameter int  EDATA_W  = 32,
    parameter int  OPRAND_W = 4,
    parameter int  TIME_W   = 32,
    parameter int  DEPTH    = 8,
    localparam int CNT_W    = $clog2(DEPTH + 1),
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    qpu_event_timing_queue_if.slave tq_i,
    input  logic                    tq_run,
    input  logic                    tq_clr,
    output logic [TIME_W-1:0]       tq_o_clk,
    output logic                    evt_o_valid,
    output logic [EDATA_W-1:0]      evt_o_edata,
    output logic [OPRAND_W-1:0]     evt_o_oprand,
    output logic [TIME_W-1:0]       evt_o_time,
    output logic                    tq_o_late,
    output logic [CNT_W-1:0]        tq_o_count,
    output logic                    tq_o_empty
);

    // Classification of the head entry against the timeline this cycle.
    typedef enum logic [1:0] {
        HEAD_EMPTY,   // nothing buffered
        HEAD_WAIT,    // timestamp still in the future
        HEAD_DUE,     // timestamp equals the timeline: issue now
        HEAD_LATE     // timestamp already passed
    } head_state_e;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [EDATA_W-1:0]  mem_edata_q  [DEPTH];
    logic [OPRAND_W-1:0] mem_oprand_q [DEPTH];
    logic [TIME_W-1:0]   mem_tdata_q  [DEPTH];

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                empty_q, empty_d;
    logic [TIME_W-1:0]   now_q, now_d;
    logic                late_q, late_d;

    logic                evt_valid_q, evt_valid_d;
    logic [EDATA_W-1:0]  evt_edata_q, evt_edata_d;
    logic [OPRAND_W-1:0] evt_oprand_q, evt_oprand_d;
    logic [TIME_W-1:0]   evt_time_q, evt_time_d;

    logic [TIME_W-1:0]   head_tdata;
    logic [TIME_W-1:0]   head_delta;
    head_state_e         head_state;

    logic                ready;
    logic                push;
    logic                pop;
    logic                issue;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // No full-bypass: a pop in the same cycle does not open a slot, which
    // keeps ready independent of the head comparison.
    assign ready           = rst_n & (count_q != CNT_W'(DEPTH)) & ~tq_clr;
    assign tq_i.tq_i_ready = ready;
    assign push            = tq_i.tq_i_valid & ready;

    // ------------------------------------------------------------------
    // Head evaluation
    // ------------------------------------------------------------------
    // The difference is taken modulo 2^TIME_W and read as signed, so an entry
    // stays "in the future" across a timeline wrap as long as it is less than
    // half the counter range ahead.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // assignment first; a path that leaves one unassigned infers a latch.
        head_state = HEAD_EMPTY;
        head_tdata = mem_tdata_q[rd_ptr_q];
        head_delta = head_tdata - now_q;

        if (count_q != '0) begin
            if (head_delta == '0) begin
                head_state = HEAD_DUE;
            end else if (head_delta[TIME_W-1]) begin
                head_state = HEAD_LATE;
            end else begin
                head_state = HEAD_WAIT;
            end
        end
    end

    // A late head always leaves the queue; the build option only decides
    // whether it also produces a strobe.
    always_comb begin
        pop = (head_state == HEAD_DUE) || (head_state == HEAD_LATE);
`ifdef QPU_TQ_LATE_DROP_EN
        issue = (head_state == HEAD_DUE);
`else
        issue = pop;
`endif
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        now_d        = tq_run ? (now_q + TIME_W'(1)) : now_q;
        late_d       = late_q | (head_state == HEAD_LATE);

        // Issue path is a one-cycle register stage; payload holds when idle.
        evt_valid_d  = issue;
        evt_edata_d  = issue ? mem_edata_q[rd_ptr_q]  : evt_edata_q;
        evt_oprand_d = issue ? mem_oprand_q[rd_ptr_q] : evt_oprand_q;
        evt_time_d   = issue ? head_tdata             : evt_time_q;

        // Flush overrides push, pop and run. Push is already blocked through
        // ready, so the storage array is never written in a flush cycle.
        if (tq_clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            now_d       = '0;
            late_d      = 1'b0;
            evt_valid_d = 1'b0;
        end

        empty_d = (count_d == '0);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            empty_q      <= 1'b1;
            now_q        <= '0;
            late_q       <= 1'b0;
            evt_valid_q  <= 1'b0;
            evt_edata_q  <= '0;
            evt_oprand_q <= '0;
            evt_time_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            empty_q      <= empty_d;
            now_q        <= now_d;
            late_q       <= late_d;
            evt_valid_q  <= evt_valid_d;
            evt_edata_q  <= evt_edata_d;
            evt_oprand_q <= evt_oprand_d;
            evt_time_q   <= evt_time_d;
        end
    end

    // NOTE: the entry array has no reset; occupancy and pointers decide which
    // slots are meaningful, so clearing the data would only cost a reset net
    // on every storage bit.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_edata_q[wr_ptr_q]  <= tq_i.tq_i_edata;
            mem_oprand_q[wr_ptr_q] <= tq_i.tq_i_oprand;
            mem_tdata_q[wr_ptr_q]  <= tq_i.tq_i_tdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tq_o_clk     = now_q;
    assign evt_o_valid  = evt_valid_q;
    assign evt_o_edata  = evt_edata_q;
    assign evt_o_oprand = evt_oprand_q;
    assign evt_o_time   = evt_time_q;
    assign tq_o_late    = late_q;
    assign tq_o_count   = count_q;
    assign tq_o_empty   = empty_q;

    // Occupancy can never exceed the buffer size.
    count_in_range_a: assert property (
        @(posedge clk) disable iff (!rst_n) count_q <= CNT_W'(DEPTH)
    );

endmodule

// File: tb/tb_qpu_event_timing_queue.sv
module tb_qpu_event_timing_queue;

    localparam int EDATA_W  = 32;
    localparam int OPRAND_W = 4;
    localparam int TIME_W   = 32;
    localparam int DEPTH    = 8;
    localparam int CNT_W    = $clog2(DEPTH + 1);

`ifdef QPU_TQ_LATE_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Clock, DUT (TIME_W=32) and a second DUT with TIME_W=8 for the wrap case
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic tq_run, tq_clr;
    logic [TIME_W-1:0]   tq_o_clk;
    logic                evt_o_valid;
    logic [EDATA_W-1:0]  evt_o_edata;
    logic [OPRAND_W-1:0] evt_o_oprand;
    logic [TIME_W-1:0]   evt_o_time;
    logic                tq_o_late;
    logic [CNT_W-1:0]    tq_o_count;
    logic                tq_o_empty;

    qpu_event_timing_queue_if #(.EDATA_W(EDATA_W), .OPRAND_W(OPRAND_W), .TIME_W(TIME_W)) tq_if ();

    qpu_event_timing_queue #(
        .EDATA_W(EDATA_W), .OPRAND_W(OPRAND_W), .TIME_W(TIME_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tq_i(tq_if), .tq_run(tq_run), .tq_clr(tq_clr),
        .tq_o_clk(tq_o_clk), .evt_o_valid(evt_o_valid), .evt_o_edata(evt_o_edata),
        .evt_o_oprand(evt_o_oprand), .evt_o_time(evt_o_time), .tq_o_late(tq_o_late),
        .tq_o_count(tq_o_count), .tq_o_empty(tq_o_empty)
    );

    logic tq_run8, tq_clr8;
    logic [7:0]          tq_o_clk8;
    logic                evt_o_valid8;
    logic [EDATA_W-1:0]  evt_o_edata8;
    logic [OPRAND_W-1:0] evt_o_oprand8;
    logic [7:0]          evt_o_time8;
    logic                tq_o_late8;
    logic [CNT_W-1:0]    tq_o_count8;
    logic                tq_o_empty8;

    qpu_event_timing_queue_if #(.EDATA_W(EDATA_W), .OPRAND_W(OPRAND_W), .TIME_W(8)) if8 ();

    qpu_event_timing_queue #(
        .EDATA_W(EDATA_W), .OPRAND_W(OPRAND_W), .TIME_W(8), .DEPTH(DEPTH)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .tq_i(if8), .tq_run(tq_run8), .tq_clr(tq_clr8),
        .tq_o_clk(tq_o_clk8), .evt_o_valid(evt_o_valid8), .evt_o_edata(evt_o_edata8),
        .evt_o_oprand(evt_o_oprand8), .evt_o_time(evt_o_time8), .tq_o_late(tq_o_late8),
        .tq_o_count(tq_o_count8), .tq_o_empty(tq_o_empty8)
    );

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [EDATA_W-1:0]  edata;
        logic [OPRAND_W-1:0] oprand;
        logic [TIME_W-1:0]   tdata;
        logic [TIME_W-1:0]   now;     // timeline value in the strobe cycle
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        int                start_now;  // timeline value in the push cycle
        bit                run;        // tq_run from the push cycle onward
        logic [TIME_W-1:0] tdata;
        bit                exp_late;
        bit                exp_pop;    // entry leaves the queue within the window
        logic [TIME_W-1:0] exp_now;    // timeline value in the strobe cycle
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue-port monitor: every strobe must match the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (evt_o_valid === 1'b1) begin
                check("strobe_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("strobe_edata",  evt_o_edata,  mon_e.edata);
                    check("strobe_oprand", evt_o_oprand, mon_e.oprand);
                    check("strobe_time",   evt_o_time,   mon_e.tdata);
                    check("strobe_now",    tq_o_clk,     mon_e.now);
                end
            end
        end
    end

    // Drive one bundle for one cycle (called at a falling edge).
    task automatic push(input logic [EDATA_W-1:0] ed, input logic [OPRAND_W-1:0] op,
                        input logic [TIME_W-1:0] td, input bit exp_strobe,
                        input logic [TIME_W-1:0] exp_now, output bit acc);
        exp_t e;
        tq_if.tq_i_valid  = 1'b1;
        tq_if.tq_i_edata  = ed;
        tq_if.tq_i_oprand = op;
        tq_if.tq_i_tdata  = td;
        #1;
        acc = tq_if.tq_i_ready;
        if (acc && exp_strobe) begin
            e.edata = ed; e.oprand = op; e.tdata = td; e.now = exp_now;
            sb.push_back(e);
        end
        @(negedge clk);
        tq_if.tq_i_valid = 1'b0;
    endtask

    // Flush with run high (flush must win), return in the first cycle after.
    task automatic do_clr(input logic run_after);
        @(negedge clk);
        tq_clr = 1'b1;
        tq_run = 1'b1;
        @(negedge clk);
        tq_clr = 1'b0;
        tq_run = run_after;
    endtask

    task automatic wait_now(input string name, input logic [TIME_W-1:0] target, input int budget);
        for (int i = 0; i < budget && tq_o_clk !== target; i++) @(negedge clk);
        check(name, tq_o_clk, target);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        bit acc;
        bit found;

        // start_now, run, tdata, late, pop, strobe-now
        vecs[0] = '{3,  1'b1, 32'd10,         1'b0, 1'b1, 32'd11}; // basic issue
        vecs[1] = '{0,  1'b1, 32'd1,          1'b0, 1'b1, 32'd2};  // minimum latency
        vecs[2] = '{20, 1'b1, 32'd5,          1'b1, 1'b1, 32'd22}; // late
        vecs[3] = '{0,  1'b0, 32'd0,          1'b0, 1'b1, 32'd0};  // run low, equal
        vecs[4] = '{4,  1'b0, 32'd9,          1'b0, 1'b0, 32'd0};  // run low, waits
        vecs[5] = '{0,  1'b1, 32'h7FFF_FFFF,  1'b0, 1'b0, 32'd0};  // far future
        vecs[6] = '{0,  1'b1, 32'h8000_0001,  1'b1, 1'b1, 32'd2};  // most-negative delta
        vecs[7] = '{0,  1'b1, 32'hFFFF_FFFF,  1'b1, 1'b1, 32'd2};  // just behind
        vecs[8] = '{5,  1'b0, 32'd4,          1'b1, 1'b1, 32'd5};  // run low, late

        rst_n = 1'b0; tq_run = 1'b0; tq_clr = 1'b0;
        tq_if.tq_i_valid = 1'b0; tq_if.tq_i_edata = '0; tq_if.tq_i_oprand = '0; tq_if.tq_i_tdata = '0;
        tq_run8 = 1'b0; tq_clr8 = 1'b0;
        if8.tq_i_valid = 1'b0; if8.tq_i_edata = '0; if8.tq_i_oprand = '0; if8.tq_i_tdata = '0;

        // ---- reset state ----
        @(negedge clk);
        #1 check("rst_ready_low", tq_if.tq_i_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready",   tq_if.tq_i_ready, 1'b1);
        check("rst_now",     tq_o_clk, 0);
        check("rst_valid",   evt_o_valid, 1'b0);
        check("rst_edata",   evt_o_edata, 0);
        check("rst_oprand",  evt_o_oprand, 0);
        check("rst_time",    evt_o_time, 0);
        check("rst_late",    tq_o_late, 1'b0);
        check("rst_count",   tq_o_count, 0);
        check("rst_empty",   tq_o_empty, 1'b1);

        // ---- single-entry vectors ----
        for (int i = 0; i < 9; i++) begin
            do_clr(1'b1);
            repeat (vecs[i].start_now) @(negedge clk);
            check($sformatf("vec%0d_start_now", i), tq_o_clk, vecs[i].start_now);
            tq_run = vecs[i].run;
            push(32'hA000_0000 + i, OPRAND_W'(i + 1), vecs[i].tdata,
                 vecs[i].exp_pop && !(DROP && vecs[i].exp_late), vecs[i].exp_now, acc);
            check($sformatf("vec%0d_accept", i), acc, 1'b1);
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d_late", i),  tq_o_late, vecs[i].exp_late);
            check($sformatf("vec%0d_count", i), tq_o_count, vecs[i].exp_pop ? 0 : 1);
            check($sformatf("vec%0d_empty", i), tq_o_empty, vecs[i].exp_pop);
            check($sformatf("vec%0d_drained", i), sb.size(), 0);
        end

        // ---- fill to capacity with run low, then release ----
        do_clr(1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            push(32'hB000_0000 + i, OPRAND_W'(i), 32'd100 + i, 1'b1, 32'd101 + i, acc);
            check($sformatf("full_accept%0d", i), acc, 1'b1);
        end
        check("full_count", tq_o_count, DEPTH);
        push(32'hBEEF_0000, 4'hF, 32'd108, 1'b0, 32'd0, acc);
        check("full_9th_refused", acc, 1'b0);
        check("full_count_hold", tq_o_count, DEPTH);
        tq_run = 1'b1;
        wait_now("full_reach_100", 32'd100, 200);
        check("full_no_bypass_ready", tq_if.tq_i_ready, 1'b0);
        @(negedge clk);
        check("full_ready_back", tq_if.tq_i_ready, 1'b1);
        check("full_count_after_pop", tq_o_count, DEPTH - 1);
        repeat (10) @(negedge clk);
        check("full_count_end", tq_o_count, 0);
        check("full_drained", sb.size(), 0);

        // ---- equal timestamps ----
        do_clr(1'b1);
        push(32'hC000_0001, 4'h1, 32'd50, 1'b1,  32'd51, acc);
        push(32'hC000_0002, 4'h2, 32'd50, !DROP, 32'd52, acc);
        wait_now("eq_reach_51", 32'd51, 80);
        check("eq_late_first", tq_o_late, 1'b0);
        @(negedge clk);
        check("eq_late_second", tq_o_late, 1'b1);
        repeat (3) @(negedge clk);
        check("eq_count", tq_o_count, 0);
        check("eq_hold_time", evt_o_time, 50);
        check("eq_hold_edata", evt_o_edata, DROP ? 32'hC000_0001 : 32'hC000_0002);
        check("eq_drained", sb.size(), 0);

        // ---- flush with a concurrent push ----
        do_clr(1'b1);
        push(32'hD000_0000, 4'h4, 32'd0, !DROP, 32'd2, acc);
        for (int i = 0; i < 3; i++) push(32'hD000_0001 + i, 4'h5, 32'd200 + i, 1'b0, 32'd0, acc);
        check("clr_pre_count", tq_o_count, 3);
        check("clr_pre_late", tq_o_late, 1'b1);
        tq_clr = 1'b1;
        push(32'hD0D0_D0D0, 4'h6, 32'd5, 1'b0, 32'd0, acc);
        tq_clr = 1'b0;
        check("clr_push_refused", acc, 1'b0);
        check("clr_count", tq_o_count, 0);
        check("clr_now", tq_o_clk, 0);
        check("clr_late", tq_o_late, 1'b0);
        check("clr_empty", tq_o_empty, 1'b1);
        check("clr_valid", evt_o_valid, 1'b0);
        repeat (12) @(negedge clk);
        check("clr_entry_lost", tq_o_count, 0);
        check("clr_drained", sb.size(), 0);

        // ---- reset in the cycle a pop would be decided ----
        do_clr(1'b1);
        push(32'hE000_0001, 4'h3, 32'd3, 1'b0, 32'd0, acc);
        @(negedge clk);
        @(negedge clk);
        check("rstmid_now", tq_o_clk, 3);
        rst_n = 1'b0;
        #1 check("rstmid_ready", tq_if.tq_i_ready, 1'b0);
        @(negedge clk);
        check("rstmid_valid", evt_o_valid, 1'b0);
        check("rstmid_count", tq_o_count, 0);
        check("rstmid_now0", tq_o_clk, 0);
        check("rstmid_time", evt_o_time, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rstmid_count_end", tq_o_count, 0);
        check("rstmid_drained", sb.size(), 0);

        // ---- timeline wrap on the 8-bit build ----
        tq_clr8 = 1'b1;
        @(negedge clk);
        tq_clr8 = 1'b0;
        tq_run8 = 1'b1;
        for (int i = 0; i < 300 && tq_o_clk8 !== 8'd254; i++) @(negedge clk);
        check("w8_reach_254", tq_o_clk8, 254);
        if8.tq_i_valid  = 1'b1;
        if8.tq_i_edata  = 32'hCAFE_0001;
        if8.tq_i_oprand = 4'h9;
        if8.tq_i_tdata  = 8'd1;
        #1 check("w8_ready", if8.tq_i_ready, 1'b1);
        @(negedge clk);
        if8.tq_i_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (evt_o_valid8 === 1'b1) found = 1'b1;
        end
        check("w8_strobe_seen", found, 1'b1);
        check("w8_strobe_now", tq_o_clk8, 2);
        check("w8_time", evt_o_time8, 1);
        check("w8_edata", evt_o_edata8, 32'hCAFE_0001);
        check("w8_late", tq_o_late8, 1'b0);
        check("w8_count", tq_o_count8, 0);

        repeat (2) @(negedge clk);
        check("final_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/qpu_event_timing_queue.md
# qpu_event_timing_queue

Timed-event issue queue on the consumer end of the QIU write-back interface. Accepts `{edata, oprand, tdata}` event bundles over a valid/ready handshake, buffers them in order, and releases each bundle to the analog/AWG event port in the cycle the local timeline counter equals its timestamp. Also owns the timeline counter and exports it as the base time the QIU adds immediates to.

## Interface
- `EDATA_W`, 32, width of event data (whole event wire).
- `OPRAND_W`, 4, width of event operand mask (one bit per event channel).
- `TIME_W`, 32, timestamp and timeline counter width.
- `DEPTH`, 8, queue entries; power of two, ≥2.

Ports:
- `clk`  in  1  — the single clock.
- `rst_n`  in  1  — reset, synchronous, active-low.
- `tq_i_valid`  in  1  — write-back bundle valid.
- `tq_i_ready`  out  1  — queue can accept.
- `tq_i_edata`  in  EDATA_W  — event data.
- `tq_i_oprand`  in  OPRAND_W  — event operand mask.
- `tq_i_tdata`  in  TIME_W  — absolute issue time.
- `tq_run`  in  1  — timeline counter enable.
- `tq_clr`  in  1  — synchronous flush of queue, counter, late flag.
- `tq_o_clk`  out  TIME_W  — current timeline value (feeds QIU base time).
- `evt_o_valid`  out  1  — one-cycle issue strobe.
- `evt_o_edata`  out  EDATA_W  — issued event data.
- `evt_o_oprand`  out  OPRAND_W  — issued operand mask.
- `evt_o_time`  out  TIME_W  — timestamp of issued entry.
- `tq_o_late`  out  1  — sticky: an entry reached head after its time.
- `tq_o_count`  out  clog2(DEPTH+1)  — occupancy.
- `tq_o_empty`  out  1  — occupancy is zero.

## Operation
- Storage: circular buffer, write pointer, read pointer, occupancy counter; pointers wrap modulo DEPTH.
- Push: `tq_i_valid & tq_i_ready`; `tq_i_ready = (count != DEPTH) & ~tq_clr`. No full-bypass: when full, ready stays low even if a pop occurs that cycle.
- Timeline: `now` increments by 1 per cycle while `tq_run=1`, wraps 2^TIME_W−1 → 0; holds when `tq_run=0`.
- Head evaluation (queue non-empty): `d = head.tdata − now` modulo 2^TIME_W, read as signed TIME_W.
  - `d > 0`: wait.
  - `d == 0`: pop; register head into `evt_o_*`, `evt_o_valid=1` next cycle.
  - `d < 0` (late): set `tq_o_late`; handling per Configuration.
- At most one pop per cycle; two entries with equal tdata issue on consecutive cycles, second counts as late.
- Comparison is independent of `tq_run`; with run low, a head whose tdata equals the held `now` still issues.
- Simultaneous push and pop: count unchanged, both pointers advance.
- `tq_clr=1`: next cycle pointers, count, `now`, `tq_o_late`, `evt_o_valid` all zero; push that cycle is refused. `tq_clr` has priority over push, pop, and run.
- Non-monotonic tdata order is not reordered; later entries wait behind the head.

## Timing
- Reset (`rst_n=0` at rising edge): `tq_i_ready=0` during reset, then 1; `tq_o_clk=0`, `evt_o_valid=0`, `evt_o_edata=0`, `evt_o_oprand=0`, `evt_o_time=0`, `tq_o_late=0`, `tq_o_count=0`, `tq_o_empty=1`. Reset mid-operation discards all entries; no strobe is emitted in the reset cycle or the cycle after.
- Entry accepted in cycle N is head-eligible at N+1; minimum accept-to-strobe latency 2 cycles.
- Pop decided in cycle N (`now == tdata` in N) → `evt_o_valid` high in N+1 with `evt_o_time` = tdata. Fixed one-cycle pipeline offset, identical for all entries.
- `evt_o_*` data hold their last value when `evt_o_valid=0`.
- `tq_o_count` and `tq_o_empty` are registered and reflect the state after the previous edge.

## Configuration
- `QPU_TQ_LATE_DROP_EN` defined: a late head is popped and discarded, no strobe; `tq_o_late` set.
- Not defined: a late head is issued immediately (strobe next cycle, `evt_o_time` = original tdata); `tq_o_late` set.

## Test plan
- Reset, run=1, push tdata=10 at now=3 → strobe in cycle where now=11, evt_o_time=10, late=0, count back to 0.
- Push 8 entries tdata=100..107 with run=0 → 9th push sees ready=0; enable run → strobes 8 consecutive cycles, ready returns after first pop.
- Push tdata=5 at now=20 → late=1; without macro strobe with evt_o_time=5; with `QPU_TQ_LATE_DROP_EN` no strobe, count decrements.
- Preload now near 2^TIME_W−2 (run from clr, TIME_W=8 build), push tdata=1 → issues after wrap at now=1, late=0.
- Two entries tdata=50,50 → strobes at now=51 and 52, late=1 after second.
- Queue holding 3 entries, assert tq_clr with a concurrent push → next cycle count=0, now=0, late=0, no strobes; pushed entry lost.
